// File: rtl/uart_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_arb_pkg
//  Description : Shared types and constants for the UART transmit arbiter:
//                FSM state encoding (2-bit), grant index width and the
//                default watchdog window in clk cycles.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_arb_pkg;

    // Width of grant_id / last-grant index; covers up to 8 requesters.
    localparam int c_GID_W = 3;

    // Default clk cycles allowed between tx_start and tx_done_tick.
    localparam int c_WDOG_CYC_DFLT = 1048576;

    typedef enum logic [1:0] {
        c_ST_IDLE  = 2'd0,
        c_ST_START = 2'd1,
        c_ST_WAIT  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin selector. The search starts at
//                last+1 and wraps from NREQ-1 back to 0; the first active
//                request found wins.
//  Ports       : req  [NREQ-1:0]    request vector
//                last [c_GID_W-1:0] index of the previous winner
//                gnt  [NREQ-1:0]    one-hot grant (all zero when no request)
//                idx  [c_GID_W-1:0] index of the winner
//                any                at least one request is active
//  Revision    : 1.0  initial release
// ============================================================================
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]    req,
    input  logic [c_GID_W-1:0] last,
    output logic [NREQ-1:0]    gnt,
    output logic [c_GID_W-1:0] idx,
    output logic               any
);

    // Outer loop walks priority offsets 1..NREQ from the last winner; the
    // inner loop keeps every bit-select at a constant index.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!any && req[i] && (i == ((int'(last) + k) % NREQ))) begin
                    gnt[i] = 1'b1;
                    idx    = c_GID_W'(i);
                    any    = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Round-robin arbiter feeding single bytes from NREQ
//                requesters into one UART transmitter. IDLE accepts one byte,
//                START pulses tx_start, WAIT holds until tx_done_tick.
//  Ports       : clk           clock, rising edge
//                reset         asynchronous active-low reset
//                req_valid     per-requester byte-available flags
//                req_data      byte of requester i on bits [8i+7:8i]
//                req_ready     one-hot accept (IDLE only)
//                tx_start      one-cycle start pulse to the transmitter
//                tx_din        byte to the transmitter
//                tx_done_tick  end-of-frame pulse from the transmitter
//                busy          high in START and WAIT
//                grant_id      owner of the current frame
//                wdog_err      one-cycle pulse on watchdog abort
//  Options     : UART_ARB_WDOG_EN - build the WAIT-state watchdog; when
//                undefined wdog_err is tied low and WAIT exits only on
//                tx_done_tick.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int WDOG_CYC = c_WDOG_CYC_DFLT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [8*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]     req_ready,
    output logic                tx_start,
    output logic [7:0]          tx_din,
    input  logic                tx_done_tick,
    output logic                busy,
    output logic [c_GID_W-1:0]  grant_id,
    output logic                wdog_err
);

    // Elaboration-time guard on the legal parameter ranges.
    generate
        if (NREQ < 2 || NREQ > 8 || WDOG_CYC < 2) begin : g_bad_param
            $error("uart_tx_arbiter: NREQ must be 2..8 and WDOG_CYC >= 2");
        end
    endgenerate

    state_t              r_state;
    state_t              w_state_nxt;
    logic [7:0]          r_tx_din;
    logic [c_GID_W-1:0]  r_grant_id;
    logic [c_GID_W-1:0]  r_last_grant;

    logic [NREQ-1:0]     w_gnt;
    logic [c_GID_W-1:0]  w_pick_idx;
    logic                w_pick_any;
    logic                w_accept;
    logic [7:0]          w_sel_byte;

    rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .req  (req_valid),
        .last (r_last_grant),
        .gnt  (w_gnt),
        .idx  (w_pick_idx),
        .any  (w_pick_any)
    );

    // The winner's valid is high by construction, so any winner in IDLE is
    // a completed handshake.
    assign w_accept = (r_state == c_ST_IDLE) && w_pick_any;

    // AND-OR byte mux driven by the one-hot grant.
    always_comb begin
        w_sel_byte = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_sel_byte = w_sel_byte | (req_data[8*i +: 8] & {8{w_gnt[i]}});
        end
    end

`ifdef UART_ARB_WDOG_EN
    localparam int                c_WCW       = $clog2(WDOG_CYC);
    localparam logic [c_WCW-1:0]  c_WDOG_LAST = c_WCW'(WDOG_CYC - 1);

    logic [c_WCW-1:0] r_wdog_cnt;
    logic             r_wdog_err;
    logic             w_wdog_hit;

    // A done tick on the timeout cycle wins over the abort.
    assign w_wdog_hit = (r_state == c_ST_WAIT) && (r_wdog_cnt == c_WDOG_LAST)
                        && !tx_done_tick;

    // START always leads into WAIT, so clearing there zeroes the count on
    // the first WAIT cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wdog_cnt <= '0;
            r_wdog_err <= 1'b0;
        end else begin
            r_wdog_err <= w_wdog_hit;
            if (r_state == c_ST_START) begin
                r_wdog_cnt <= '0;
            end else if (r_state == c_ST_WAIT) begin
                r_wdog_cnt <= r_wdog_cnt + 1'b1;
            end
        end
    end

    assign wdog_err = r_wdog_err;
`else
    assign wdog_err = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_pick_any) begin
                    w_state_nxt = c_ST_START;
                end
            end
            c_ST_START: begin
                w_state_nxt = c_ST_WAIT;
            end
            c_ST_WAIT: begin
                if (tx_done_tick) begin
                    w_state_nxt = c_ST_IDLE;
                end
`ifdef UART_ARB_WDOG_EN
                else if (w_wdog_hit) begin
                    w_state_nxt = c_ST_IDLE;
                end
`endif
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= c_ST_IDLE;
            r_tx_din     <= '0;
            r_grant_id   <= '0;
            r_last_grant <= c_GID_W'(NREQ - 1);
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_tx_din     <= w_sel_byte;
                r_grant_id   <= w_pick_idx;
                r_last_grant <= w_pick_idx;
            end
        end
    end

    // req_ready is gated by reset so nothing is offered while the block is
    // held in reset, even though IDLE is the reset state.
    assign req_ready = (r_state == c_ST_IDLE && reset) ? w_gnt : '0;
    assign tx_start  = (r_state == c_ST_START);
    assign busy      = (r_state != c_ST_IDLE);
    assign tx_din    = r_tx_din;
    assign grant_id  = r_grant_id;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_arbiter
//  Description : Directed self-checking bench for uart_tx_arbiter (NREQ=4,
//                WDOG_CYC=16). Inputs change 1 time unit after the rising
//                edge; outputs are checked before the next rising edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_tx_arbiter;

    logic        clk          = 1'b0;
    logic        reset        = 1'b1;
    logic [3:0]  req_valid    = '0;
    logic [31:0] req_data     = '0;
    logic        tx_done_tick = 1'b0;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_din;
    logic        busy;
    logic [2:0]  grant_id;
    logic        wdog_err;

    int n_checks = 0;
    int n_errors = 0;
    int n_start  = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NREQ     (4),
        .WDOG_CYC (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .tx_start     (tx_start),
        .tx_din       (tx_din),
        .tx_done_tick (tx_done_tick),
        .busy         (busy),
        .grant_id     (grant_id),
        .wdog_err     (wdog_err)
    );

    // One count per cycle with tx_start high.
    always @(negedge clk) begin
        if (tx_start === 1'b1) n_start++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " req_ready"}, 32'(req_ready), 32'h0);
        chk({tag, " tx_start"},  32'(tx_start),  32'h0);
        chk({tag, " tx_din"},    32'(tx_din),    32'h0);
        chk({tag, " grant_id"},  32'(grant_id),  32'h0);
        chk({tag, " busy"},      32'(busy),      32'h0);
        chk({tag, " wdog_err"},  32'(wdog_err),  32'h0);
    endtask

    // Entered in IDLE with all requesters valid; done arrives 5 cycles
    // after tx_start.
    task automatic frame(input int id, input logic [7:0] b);
        int n0;
        n0 = n_start;
        chk("rr req_ready", 32'(req_ready), 32'(1 << id));
        tick();
        chk("rr tx_start", 32'(tx_start), 32'h1);
        chk("rr grant_id", 32'(grant_id), 32'(id));
        chk("rr tx_din",   32'(tx_din),   32'(b));
        chk("rr ready in START", 32'(req_ready), 32'h0);
        repeat (5) tick();
        chk("rr busy in WAIT", 32'(busy), 32'h1);
        tx_done_tick = 1'b1;
        tick();
        tx_done_tick = 1'b0;
        chk("rr idle after done", 32'(busy), 32'h0);
        chk("rr tx_din held", 32'(tx_din), 32'(b));
        chk("rr one start", 32'(n_start - n0), 32'h1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n0;

        // Power-on reset, with all requesters valid during reset.
        #2 reset = 1'b0;
        #1;
        chk_reset_outputs("por");
        req_valid = 4'hF;
        tick();
        tick();
        chk("por ready held low", 32'(req_ready), 32'h0);
        req_valid = 4'h0;
        reset = 1'b1;
        #1;

        // Only requester 2 valid with 0xA5.
        req_data  = 32'h00A5_0000;
        req_valid = 4'b0100;
        #1;
        chk("r2 req_ready", 32'(req_ready), 32'h4);
        chk("r2 no start yet", 32'(tx_start), 32'h0);
        n0 = n_start;
        tick();
        req_valid = 4'b0000;
        chk("r2 tx_start", 32'(tx_start), 32'h1);
        chk("r2 tx_din",   32'(tx_din),   32'hA5);
        chk("r2 grant_id", 32'(grant_id), 32'h2);
        chk("r2 ready low", 32'(req_ready), 32'h0);
        tick();
        chk("r2 start one cycle", 32'(tx_start), 32'h0);
        chk("r2 busy", 32'(busy), 32'h1);
        tick();
        tick();
        chk("r2 busy still", 32'(busy), 32'h1);
        tx_done_tick = 1'b1;
        tick();
        tx_done_tick = 1'b0;
        chk("r2 idle", 32'(busy), 32'h0);
        chk("r2 tx_din held", 32'(tx_din), 32'hA5);
        chk("r2 grant held", 32'(grant_id), 32'h2);
        chk("r2 one start", 32'(n_start - n0), 32'h1);

        // Done tick in IDLE is ignored.
        tx_done_tick = 1'b1;
        tick();
        tx_done_tick = 1'b0;
        chk("idle done busy", 32'(busy), 32'h0);
        chk("idle done start", 32'(tx_start), 32'h0);

        // Valid withdrawn before the edge: nothing is accepted.
        req_valid = 4'b0001;
        #1;
        chk("withdraw ready shown", 32'(req_ready), 32'h1);
        req_valid = 4'b0000;
        tick();
        chk("withdraw busy", 32'(busy), 32'h0);
        chk("withdraw grant", 32'(grant_id), 32'h2);

        // Done tick in START is ignored; frame continues into WAIT.
        req_data  = 32'h0000_5A00;
        req_valid = 4'b0010;
        #1;
        chk("r1 req_ready", 32'(req_ready), 32'h2);
        n0 = n_start;
        tick();
        req_valid    = 4'b0000;
        tx_done_tick = 1'b1;
        chk("r1 tx_start", 32'(tx_start), 32'h1);
        chk("r1 grant_id", 32'(grant_id), 32'h1);
        chk("r1 tx_din",   32'(tx_din),   32'h5A);
        tick();
        tx_done_tick = 1'b0;
        chk("start done busy", 32'(busy), 32'h1);
        chk("start done no restart", 32'(tx_start), 32'h0);
        chk("start done one start", 32'(n_start - n0), 32'h1);

`ifdef UART_ARB_WDOG_EN
        // First WAIT cycle is now; abort pulse lands 16 cycles later.
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (k < 16) begin
                chk("wdog quiet", 32'(wdog_err), 32'h0);
                chk("wdog busy",  32'(busy),     32'h1);
            end else if (k == 16) begin
                chk("wdog pulse", 32'(wdog_err), 32'h1);
                chk("wdog idle",  32'(busy),     32'h0);
            end else begin
                chk("wdog one cycle", 32'(wdog_err), 32'h0);
            end
        end
        req_valid = 4'b1000;
        #1;
        chk("r3 req_ready", 32'(req_ready), 32'h8);
        tick();
        req_valid = 4'b0000;
        tick();
        tick();
`else
        repeat (20) tick();
        chk("no wdog busy",  32'(busy),     32'h1);
        chk("no wdog err",   32'(wdog_err), 32'h0);
        chk("no wdog grant", 32'(grant_id), 32'h1);
`endif

        // Reset mid-WAIT with all requesters valid.
        chk("pre-reset busy", 32'(busy), 32'h1);
        req_valid = 4'hF;
        reset     = 1'b0;
        #1;
        chk_reset_outputs("mid");
        tick();
        chk("mid ready held low", 32'(req_ready), 32'h0);
        req_data = 32'h4433_2211;
        reset    = 1'b1;
        #1;

        // Rotation 0,1,2,3,0 with requester 0 first after reset.
        frame(0, 8'h11);
        frame(1, 8'h22);
        frame(2, 8'h33);
        frame(3, 8'h44);
        frame(0, 8'h11);
        req_valid = 4'h0;
        #1;
        chk("end ready low", 32'(req_ready), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
